// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: result classes, op codes, divider FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ex_pkg;

  // Result class, selects which ALU group drives the result.
  localparam logic [2:0] ALU_SEL_NOP    = 3'b000;
  localparam logic [2:0] ALU_SEL_LOGIC  = 3'b001;
  localparam logic [2:0] ALU_SEL_SHIFT  = 3'b010;
  localparam logic [2:0] ALU_SEL_MOVE   = 3'b011;
  localparam logic [2:0] ALU_SEL_ARITH  = 3'b100;
  localparam logic [2:0] ALU_SEL_MULDIV = 3'b101;

  // ORI shares the OR funct code; LUI has no funct so it reuses its primary opcode.
  localparam logic [7:0] ALU_OP_ORI   = 8'b0010_0101;
  localparam logic [7:0] ALU_OP_OR    = ALU_OP_ORI;
  localparam logic [7:0] ALU_OP_AND   = 8'h24;
  localparam logic [7:0] ALU_OP_XOR   = 8'h26;
  localparam logic [7:0] ALU_OP_NOR   = 8'h27;
  localparam logic [7:0] ALU_OP_LUI   = 8'h0F;
  localparam logic [7:0] ALU_OP_SLL   = 8'h00;
  localparam logic [7:0] ALU_OP_SRL   = 8'h02;
  localparam logic [7:0] ALU_OP_SRA   = 8'h03;
  localparam logic [7:0] ALU_OP_MFHI  = 8'h10;
  localparam logic [7:0] ALU_OP_MTHI  = 8'h11;
  localparam logic [7:0] ALU_OP_MFLO  = 8'h12;
  localparam logic [7:0] ALU_OP_MTLO  = 8'h13;
  localparam logic [7:0] ALU_OP_MULT  = 8'h18;
  localparam logic [7:0] ALU_OP_MULTU = 8'h19;
  localparam logic [7:0] ALU_OP_DIV   = 8'h1A;
  localparam logic [7:0] ALU_OP_DIVU  = 8'h1B;
  localparam logic [7:0] ALU_OP_ADD   = 8'h20;
  localparam logic [7:0] ALU_OP_ADDU  = 8'h21;
  localparam logic [7:0] ALU_OP_SUB   = 8'h22;
  localparam logic [7:0] ALU_OP_SUBU  = 8'h23;
  localparam logic [7:0] ALU_OP_SLT   = 8'h2A;
  localparam logic [7:0] ALU_OP_SLTU  = 8'h2B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/ex_if.sv
// Execute-stage bus: decoded instruction in, registered EX/MEM result out, stall back upstream.
// Latency: n/a (wiring only).
// Backpressure: stall_req tells the producer to hold the in_* fields stable.
// master drives in_*/flush and observes out_*/stall_req; slave is the execute unit.
interface ex_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [DATA_W-1:0] in_reg1_data;
  logic [DATA_W-1:0] in_reg2_data;
  logic [ADDR_W-1:0] in_wr_address;
  logic              in_wr_enable;
  logic [7:0]        in_alu_op;
  logic [2:0]        in_alu_sel;
  logic              flush;
  logic              out_valid;
  logic [ADDR_W-1:0] out_wr_address;
  logic [DATA_W-1:0] out_wr_data;
  logic              out_wr_enable;
  logic              out_ovf;
  logic              stall_req;

  modport master (
    output in_valid, in_reg1_data, in_reg2_data, in_wr_address, in_wr_enable,
           in_alu_op, in_alu_sel, flush,
    input  out_valid, out_wr_address, out_wr_data, out_wr_enable, out_ovf, stall_req
  );

  modport slave (
    input  in_valid, in_reg1_data, in_reg2_data, in_wr_address, in_wr_enable,
           in_alu_op, in_alu_sel, flush,
    output out_valid, out_wr_address, out_wr_data, out_wr_enable, out_ovf, stall_req
  );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider (signed/unsigned), one quotient bit per cycle.
// Latency: start -> DONE after DATA_W+1 edges (1 edge when divisor is zero).
// Backpressure: none; busy tells the parent to stall, flush aborts to IDLE.
// Ports: clk, rst_n, start, flush, sign, dividend, divisor -> busy, done, quo, rem (valid in DONE).
module ex_div
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem
);
  localparam int CNT_W = $clog2(DATA_W);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvsr, a_mag, b_mag, q_step, r_step;
  logic [DATA_W:0]   partial, diff;
  logic              a_neg, b_neg, q_neg, r_neg;

  assign a_neg = sign & dividend[DATA_W-1];
  assign b_neg = sign & divisor[DATA_W-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign partial = {rem, quo[DATA_W-1]};
  assign diff    = partial - {1'b0, dvsr};
  assign q_step  = {quo[DATA_W-2:0], ~diff[DATA_W]};
  assign r_step  = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      dvsr  <= '0;
      quo   <= '0;
      rem   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dvsr  <= b_mag;
          cnt   <= '0;
          if (divisor == '0) begin
            quo   <= '1;
            rem   <= dividend;
            state <= DIV_DONE;
          end else begin
            quo   <= a_mag;
            rem   <= '0;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          cnt <= cnt + 1'b1;
          // Signs are folded in on the final step so DONE presents registered results.
          if (cnt == CNT_W'(DATA_W - 1)) begin
            quo   <= q_neg ? -q_step : q_step;
            rem   <= r_neg ? -r_step : r_step;
            state <= DIV_DONE;
          end else begin
            quo <= q_step;
            rem <= r_step;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_unit.sv
// MIPS32 execute stage: ALU, HI/LO, single-cycle MULT, iterative DIV; registered EX/MEM output.
// Latency: 1 edge for all ops except DIV (DATA_W+2 cycles, 2 for divide by zero).
// Backpressure: stall_req high while a divide starts or is in flight; upstream holds inputs.
// Ports: clk, rst_n (sync, active-low), bus (ex_if.slave: in_* instruction, flush, out_* result, stall_req).
module ex_unit
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int ADDR_W  = 5
) (
  input logic clk,
  input logic rst_n,
  ex_if.slave bus
);
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0]   a, b, b_eff, sum, res, hi, lo, div_quo, div_rem;
  logic [2*DATA_W-1:0] prod;
  logic [SHAMT_W-1:0]  shamt;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          op;
  logic [2:0]          sel;
  logic sub_op, add_ovf, res_we, res_ovf;
  logic is_div, div_start, div_busy, div_done, div_commit, issue;

  assign a     = bus.in_reg1_data;
  assign b     = bus.in_reg2_data;
  assign op    = bus.in_alu_op;
  assign sel   = bus.in_alu_sel;
  assign addr  = bus.in_wr_address;
  assign shamt = a[SHAMT_W-1:0];

  assign sub_op  = (op == ALU_OP_SUB) || (op == ALU_OP_SUBU);
  assign b_eff   = sub_op ? ~b : b;
  assign sum     = a + b_eff + {{(DATA_W-1){1'b0}}, sub_op};
  assign add_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
  assign prod    = (op == ALU_OP_MULT)
                 ? ({{DATA_W{a[MSB]}}, a} * {{DATA_W{b[MSB]}}, b})
                 : ({{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b});

  // A divide only starts from IDLE; during DONE the same DIV is still presented and must not restart.
  assign is_div     = (sel == ALU_SEL_MULDIV) && ((op == ALU_OP_DIV) || (op == ALU_OP_DIVU));
  assign div_start  = bus.in_valid & ~bus.flush & is_div & ~div_busy & ~div_done;
  assign bus.stall_req = rst_n & (div_start | (div_busy & ~bus.flush));
  assign div_commit = div_done & ~bus.flush;
  assign issue      = bus.in_valid & ~bus.flush & ~bus.stall_req;

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .flush    (bus.flush),
    .sign     (op == ALU_OP_DIV),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    res     = '0;
    res_we  = bus.in_wr_enable;
    res_ovf = 1'b0;
    case (sel)
      ALU_SEL_LOGIC: case (op)
        ALU_OP_AND: res = a & b;
        ALU_OP_OR:  res = a | b;
        ALU_OP_XOR: res = a ^ b;
        ALU_OP_NOR: res = ~(a | b);
        ALU_OP_LUI: res = b << (DATA_W / 2);
        default:    res = '0;
      endcase
      ALU_SEL_SHIFT: case (op)
        ALU_OP_SLL: res = b << shamt;
        ALU_OP_SRL: res = b >> shamt;
        ALU_OP_SRA: res = $signed(b) >>> shamt;
        default:    res = '0;
      endcase
      ALU_SEL_ARITH: case (op)
        ALU_OP_ADD, ALU_OP_SUB: begin
          res = sum;
          if (add_ovf) begin
            res_we  = 1'b0;
            res_ovf = 1'b1;
          end
        end
        ALU_OP_ADDU, ALU_OP_SUBU: res = sum;
        ALU_OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
        ALU_OP_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
        default:     res = '0;
      endcase
      ALU_SEL_MOVE: case (op)
        ALU_OP_MFHI: res = hi;
        ALU_OP_MFLO: res = lo;
        ALU_OP_MTHI, ALU_OP_MTLO: res_we = 1'b0;
        default:     res = '0;
      endcase
      ALU_SEL_MULDIV: case (op)
        ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU: res_we = 1'b0;
        default: res = '0;
      endcase
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (div_commit) begin
      lo <= div_quo;
      hi <= div_rem;
    end else if (issue) begin
      if (sel == ALU_SEL_MOVE && op == ALU_OP_MTHI) hi <= a;
      if (sel == ALU_SEL_MOVE && op == ALU_OP_MTLO) lo <= a;
      if (sel == ALU_SEL_MULDIV && (op == ALU_OP_MULT || op == ALU_OP_MULTU)) {hi, lo} <= prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_wr_address <= '0;
      bus.out_wr_data    <= '0;
      bus.out_wr_enable  <= 1'b0;
      bus.out_ovf        <= 1'b0;
    end else begin
      bus.out_valid      <= 1'b0;
      bus.out_wr_address <= addr;
      bus.out_wr_data    <= '0;
      bus.out_wr_enable  <= 1'b0;
      bus.out_ovf        <= 1'b0;
      if (div_commit) begin
        bus.out_valid <= 1'b1;
      end else if (issue) begin
        bus.out_valid     <= 1'b1;
        bus.out_wr_data   <= res;
        bus.out_wr_enable <= res_we;
        bus.out_ovf       <= res_ovf;
      end
    end
  end
endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench for ex_unit (DATA_W=32): scoreboard on the output stream plus inline stall/reset checks.
module tb_ex_unit;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_if #(.DATA_W(32), .ADDR_W(5)) bus();

  ex_unit #(.DATA_W(32), .SHAMT_W(5), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        we;
    logic        ovf;
    logic [4:0]  addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Divide table: op, dividend, divisor, expected LO, HI, stall cycles.
  logic [7:0]  dv_op [7] = '{ALU_OP_DIV, ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_DIVU, ALU_OP_DIVU, ALU_OP_DIV, ALU_OP_DIV};
  logic [31:0] dv_a  [7] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF9, 32'd7};
  logic [31:0] dv_b  [7] = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'd10, 32'd0, 32'd0, 32'hFFFF_FFFE};
  logic [31:0] dv_lo [7] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd14, 32'h1999_9999, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
  logic [31:0] dv_hi [7] = '{32'hFFFF_FFFF, 32'd0, 32'd2, 32'd5, 32'd5, 32'hFFFF_FFF9, 32'd1};
  int          dv_st [7] = '{33, 33, 33, 33, 1, 1, 33};

  // Output-stream checker: every valid result must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got addr=%0d data=%h we=%b ovf=%b, required no output",
                 bus.out_wr_address, bus.out_wr_data, bus.out_wr_enable, bus.out_ovf);
      end else begin
        mon_e = sb.pop_front();
        if (bus.out_wr_enable !== mon_e.we || bus.out_ovf !== mon_e.ovf ||
            bus.out_wr_address !== mon_e.addr || (mon_e.we && bus.out_wr_data !== mon_e.data)) begin
          fails++;
          $display("FAIL sb_result: got addr=%0d data=%h we=%b ovf=%b, required addr=%0d data=%h we=%b ovf=%b",
                   bus.out_wr_address, bus.out_wr_data, bus.out_wr_enable, bus.out_ovf,
                   mon_e.addr, mon_e.data, mon_e.we, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_wr_enable = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic we);
    bus.in_valid      = 1'b1;
    bus.in_alu_sel    = sel;
    bus.in_alu_op     = op;
    bus.in_reg1_data  = a;
    bus.in_reg2_data  = b;
    bus.in_wr_address = addr;
    bus.in_wr_enable  = we;
    bus.flush         = 1'b0;
  endtask

  // One-cycle issue of an instruction whose result is expected on the next output.
  task automatic send(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] addr, input logic we,
                      input logic [31:0] e_data, input logic e_we, input logic e_ovf);
    exp_t e;
    e.data = e_data; e.we = e_we; e.ovf = e_ovf; e.addr = addr;
    sb.push_back(e);
    drive(sel, op, a, b, addr, we);
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    drive(ALU_SEL_MULDIV, ALU_OP_DIV, 32'd9, 32'd2, 5'd3, 1'b0);
    #1;
    tests++;
    if (bus.stall_req !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got %b, required 0", bus.stall_req);
    end
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_wr_enable, bus.out_ovf, bus.out_wr_address, bus.out_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b we=%b ovf=%b addr=%0d data=%h, required all zero",
               bus.out_valid, bus.out_wr_enable, bus.out_ovf, bus.out_wr_address, bus.out_wr_data);
    end
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    send(ALU_SEL_MOVE, ALU_OP_MFHI, 0, 0, 5'd1, 1'b1, 32'h0, 1'b1, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFLO, 0, 0, 5'd2, 1'b1, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_logic();
    send(ALU_SEL_LOGIC, ALU_OP_ORI, 32'h0000_F0F0, 32'h0000_0F0F, 5'd1, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0);
    send(ALU_SEL_LOGIC, ALU_OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd2, 1'b1, 32'h0F00_0F00, 1'b1, 1'b0);
    send(ALU_SEL_LOGIC, ALU_OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3, 1'b1, 32'h0FF0_0FF0, 1'b1, 1'b0);
    send(ALU_SEL_LOGIC, ALU_OP_NOR, 32'hF0F0_0000, 32'h0000_000F, 5'd4, 1'b1, 32'h0F0F_FFF0, 1'b1, 1'b0);
    send(ALU_SEL_LOGIC, ALU_OP_LUI, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 32'h1234_0000, 1'b1, 1'b0);
    send(ALU_SEL_LOGIC, ALU_OP_ORI, 32'h1, 32'h2, 5'd6, 1'b0, 32'h3, 1'b0, 1'b0);
    send(ALU_SEL_LOGIC, 8'hFF, 32'h1, 32'h2, 5'd7, 1'b1, 32'h0, 1'b1, 1'b0);
    send(3'b111, ALU_OP_OR, 32'h1, 32'h2, 5'd8, 1'b1, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_shift();
    send(ALU_SEL_SHIFT, ALU_OP_SRA, 32'd4, 32'h8000_0000, 5'd1, 1'b1, 32'hF800_0000, 1'b1, 1'b0);
    send(ALU_SEL_SHIFT, ALU_OP_SRA, 32'd4, 32'h7000_0000, 5'd2, 1'b1, 32'h0700_0000, 1'b1, 1'b0);
    send(ALU_SEL_SHIFT, ALU_OP_SLL, 32'h20, 32'h1234_5678, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    send(ALU_SEL_SHIFT, ALU_OP_SLL, 32'd31, 32'h3, 5'd4, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
    send(ALU_SEL_SHIFT, ALU_OP_SRL, 32'd8, 32'h8000_0000, 5'd5, 1'b1, 32'h0080_0000, 1'b1, 1'b0);
  endtask

  task automatic test_arith();
    send(ALU_SEL_ARITH, ALU_OP_ADD,  32'h7FFF_FFFF, 32'h1, 5'd1, 1'b1, 32'h0, 1'b0, 1'b1);
    send(ALU_SEL_ARITH, ALU_OP_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd2, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
    send(ALU_SEL_ARITH, ALU_OP_ADD,  32'd5, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'h2, 1'b1, 1'b0);
    send(ALU_SEL_ARITH, ALU_OP_SUB,  32'h8000_0000, 32'h1, 5'd4, 1'b1, 32'h0, 1'b0, 1'b1);
    send(ALU_SEL_ARITH, ALU_OP_SUBU, 32'h8000_0000, 32'h1, 5'd5, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    send(ALU_SEL_ARITH, ALU_OP_SUB,  32'd3, 32'd5, 5'd6, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    send(ALU_SEL_ARITH, ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'h1, 1'b1, 1'b0);
    send(ALU_SEL_ARITH, ALU_OP_SLT,  32'd1, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'h0, 1'b1, 1'b0);
    send(ALU_SEL_ARITH, ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1, 32'h1, 1'b1, 1'b0);
  endtask

  task automatic test_flush_invalid();
    send(ALU_SEL_MOVE, ALU_OP_MTHI, 32'h0000_AAAA, 32'h0, 5'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(ALU_SEL_MOVE, ALU_OP_MTHI, 32'h0000_BBBB, 32'h0, 5'd2, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    drive(ALU_SEL_LOGIC, ALU_OP_ORI, 32'h1, 32'h2, 5'd3, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    idle();
    send(ALU_SEL_MOVE, ALU_OP_MFHI, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0000_AAAA, 1'b1, 1'b0);
  endtask

  task automatic test_mul_hilo();
    send(ALU_SEL_MULDIV, ALU_OP_MULT, 32'hFFFF_FFFD, 32'd5, 5'd1, 1'b1, 32'h0, 1'b0, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFLO, 0, 0, 5'd2, 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFHI, 0, 0, 5'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(ALU_SEL_MULDIV, ALU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b0, 32'h0, 1'b0, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFHI, 0, 0, 5'd5, 1'b1, 32'h1, 1'b1, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFLO, 0, 0, 5'd6, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MTLO, 32'h55, 0, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFLO, 0, 0, 5'd8, 1'b1, 32'h55, 1'b1, 1'b0);
  endtask

  task automatic test_div();
    exp_t e;
    int   n;
    for (int i = 0; i < 7; i++) begin
      drive(ALU_SEL_MULDIV, dv_op[i], dv_a[i], dv_b[i], 5'd9, 1'b0);
      #1;
      n = 0;
      while (bus.stall_req === 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
        #1;
      end
      tests++;
      if (n != dv_st[i]) begin
        fails++; $display("FAIL div_stall[%0d]: got %0d cycles, required %0d", i, n, dv_st[i]);
      end
      e.data = 32'h0; e.we = 1'b0; e.ovf = 1'b0; e.addr = 5'd9;
      sb.push_back(e);
      @(negedge clk);
      idle();
      send(ALU_SEL_MOVE, ALU_OP_MFLO, 0, 0, 5'd10, 1'b1, dv_lo[i], 1'b1, 1'b0);
      send(ALU_SEL_MOVE, ALU_OP_MFHI, 0, 0, 5'd11, 1'b1, dv_hi[i], 1'b1, 1'b0);
    end
  endtask

  task automatic test_div_flush();
    send(ALU_SEL_MOVE, ALU_OP_MTHI, 32'h1111_1111, 0, 5'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MTLO, 32'h2222_2222, 0, 5'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(ALU_SEL_MULDIV, ALU_OP_DIV, 32'd100, 32'd7, 5'd3, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (bus.stall_req !== 1'b1) begin
      fails++; $display("FAIL flush_pre_stall: got %b, required 1", bus.stall_req);
    end
    bus.flush = 1'b1;
    #1;
    tests++;
    if (bus.stall_req !== 1'b0) begin
      fails++; $display("FAIL flush_stall_drop: got %b, required 0", bus.stall_req);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.stall_req !== 1'b0) begin
      fails++; $display("FAIL flush_idle_stall: got %b, required 0", bus.stall_req);
    end
    @(negedge clk);
    send(ALU_SEL_MOVE, ALU_OP_MFLO, 0, 0, 5'd4, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFHI, 0, 0, 5'd5, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_div();
    send(ALU_SEL_MOVE, ALU_OP_MTHI, 32'h0000_1234, 0, 5'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MTLO, 32'h0000_5678, 0, 5'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(ALU_SEL_MULDIV, ALU_OP_DIVU, 32'd1000, 32'd3, 5'd3, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.stall_req !== 1'b0) begin
      fails++; $display("FAIL rstdiv_stall: got %b, required 0", bus.stall_req);
    end
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_wr_enable, bus.out_ovf, bus.out_wr_address, bus.out_wr_data,
         bus.stall_req} !== '0) begin
      fails++;
      $display("FAIL rstdiv_outputs: got valid=%b we=%b ovf=%b addr=%0d data=%h stall=%b, required all zero",
               bus.out_valid, bus.out_wr_enable, bus.out_ovf, bus.out_wr_address, bus.out_wr_data,
               bus.stall_req);
    end
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    send(ALU_SEL_MOVE, ALU_OP_MFHI, 0, 0, 5'd4, 1'b1, 32'h0, 1'b1, 1'b0);
    send(ALU_SEL_MOVE, ALU_OP_MFLO, 0, 0, 5'd5, 1'b1, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, r;
    logic [7:0]  op;
    logic [2:0]  sel;
    int          k;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 3);
      case (k)
        0:       begin sel = ALU_SEL_ARITH; op = ALU_OP_ADDU; r = a + b; end
        1:       begin sel = ALU_SEL_ARITH; op = ALU_OP_SUBU; r = a - b; end
        2:       begin sel = ALU_SEL_LOGIC; op = ALU_OP_XOR;  r = a ^ b; end
        default: begin sel = ALU_SEL_LOGIC; op = ALU_OP_AND;  r = a & b; end
      endcase
      send(sel, op, a, b, 5'(i), 1'b1, r, 1'b1, 1'b0);
    end
  endtask

  initial begin
    idle();
    bus.in_alu_sel    = '0;
    bus.in_alu_op     = '0;
    bus.in_reg1_data  = '0;
    bus.in_reg2_data  = '0;
    bus.in_wr_address = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_logic();
    test_shift();
    test_arith();
    test_flush_invalid();
    test_mul_hilo();
    test_div();
    test_div_flush();
    test_reset_mid_div();
    test_back_to_back();
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain: got %0d results still pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
